// File: rtl/fp_ratio_pkg.sv
// fp_ratio_pkg: shared definitions for the fixed-point ratio divider.
//   - rounding-mode encodings (the spare encoding 2'b11 behaves as truncate)
//   - FSM state enum
//   - round_up(): round-up decision from mode, guard bit, sticky bit and result LSB
package fp_ratio_pkg;

  localparam logic [1:0] RND_TRUNC   = 2'b00;
  localparam logic [1:0] RND_HALF_UP = 2'b01;
  localparam logic [1:0] RND_EVEN    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DIV  = 2'b01,
    ST_RND  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // Half-to-even only rounds a pure tie up when the kept LSB is odd.
  function automatic logic round_up(input logic [1:0] mode, input logic guard,
                                    input logic sticky, input logic lsb);
    logic up;
    case (mode)
      RND_HALF_UP: up = guard;
      RND_EVEN:    up = guard & (sticky | lsb);
      default:     up = 1'b0;
    endcase
    return up;
  endfunction

endpackage

// File: rtl/fp_ratio_divstep.sv
// fp_ratio_divstep: one combinational restoring-division step.
// Ports:
//   part     in  W  partial remainder, already shifted with the next dividend bit
//   divisor  in  W  divisor (zero-extended)
//   rem_next out W  remainder after the trial subtraction (restored if negative)
//   q        out 1  quotient bit produced by this step
module fp_ratio_divstep #(
  parameter int W = 18
) (
  input  logic [W-1:0] part,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic         q
);

  logic [W:0] diff;

  // Trial subtraction; the extra MSB is the borrow that decides the quotient bit.
  always_comb begin
    diff = {1'b0, part} - {1'b0, divisor};
    q    = ~diff[W];
    if (q) begin
      rem_next = diff[W-1:0];
    end else begin
      rem_next = part;
    end
  end

endmodule

// File: rtl/fp_ratio.sv
// fp_ratio: iterative fixed-point divider out = num/den in Q(WI.WF), with
// selectable rounding, saturation and divide-by-zero reporting.
// Fixed latency: out_valid rises WI+WF+3 cycles after the acceptance cycle.
// Ports:
//   clk        in   1  clock, rising edge
//   rst        in   1  synchronous active-high reset
//   in_valid   in   1  operand pair valid
//   in_ready   out  1  high only while idle
//   num, den   in   N  integer numerator / denominator (N = WI+WF)
//   rnd_type   in   2  rounding mode: 00 trunc, 01 half away from zero, 10 half even, 11 trunc
//   out_valid  out  1  result valid (held until out_ready)
//   out_ready  in   1  consumer accepts result
//   out        out  N  quotient in Q(WI.WF)
//   dz         out  1  divide-by-zero flag
//   ovf        out  1  saturation flag
module fp_ratio
  import fp_ratio_pkg::*;
#(
  parameter int WI     = 2,
  parameter int WF     = 14,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WI+WF-1:0] num,
  input  logic [WI+WF-1:0] den,
  input  logic [1:0]       rnd_type,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WI+WF-1:0] out,
  output logic             dz,
  output logic             ovf
);

  localparam int N      = WI + WF;
  localparam int RW     = N + 2;           // remainder width incl. shifted-in bit
  localparam int W2     = N + WI + 2;      // pre-check compare width, no truncation
  localparam bit IS_SIGNED = (SIGNED != 0);
  localparam int LIM_SH = IS_SIGNED ? (WI - 1) : WI;
  localparam int CW     = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N);
  localparam logic [N:0]    SGN_LIM  = {2'b01, {(N-1){1'b0}}};

  state_t state_r, state_nxt;

  logic           accept;
  logic           num_neg, den_neg;
  logic [N:0]     num_abs, den_abs;
  logic [W2-1:0]  big_num, big_den;
  logic           pre_ovf;

  logic [1:0]     mode_r;
  logic           neg_r, num_neg_r, num_zero_r, den_zero_r, pre_ovf_r;
  logic [N:0]     den_r;
  logic [RW-1:0]  rem_r;
  logic [N:0]     dvd_r;
  logic [N:0]     quo_r;
  logic [CW-1:0]  cnt_r;

  logic [RW-1:0]  part, rem_nxt;
  logic           qbit;

  logic           guard, sticky, up, post_ovf;
  logic [N:0]     mag, mag_rnd;
  logic [N-1:0]   res_val, sat_pos, sat_neg, out_nxt;
  logic           dz_nxt, ovf_nxt;

  logic [N-1:0]   out_r;
  logic           dz_out_r, ovf_r;

  // Operand conditioning: magnitudes in N+1 bits so the most negative value does not wrap.
  always_comb begin
    accept  = in_valid && (state_r == ST_IDLE);
    num_neg = IS_SIGNED && num[N-1];
    den_neg = IS_SIGNED && den[N-1];
    if (num_neg) begin
      num_abs = ~{num[N-1], num} + {{N{1'b0}}, 1'b1};
    end else begin
      num_abs = {1'b0, num};
    end
    if (den_neg) begin
      den_abs = ~{den[N-1], den} + {{N{1'b0}}, 1'b1};
    end else begin
      den_abs = {1'b0, den};
    end
    // Guarantees the N+1-bit quotient register cannot overflow; equality in the
    // signed case is left to the post-round check so that the most negative
    // result stays representable.
    big_num = W2'(num_abs);
    big_den = W2'(den_abs) << LIM_SH;
    if (IS_SIGNED) begin
      pre_ovf = (big_num > big_den);
    end else begin
      pre_ovf = (big_num >= big_den);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) state_nxt = ST_DIV;
        else          state_nxt = ST_IDLE;
      end
      ST_DIV: begin
        if (cnt_r == LAST_CNT) state_nxt = ST_RND;
        else                   state_nxt = ST_DIV;
      end
      ST_RND:  state_nxt = ST_DONE;
      ST_DONE: begin
        if (out_ready) state_nxt = ST_IDLE;
        else           state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt;
  end

  // The shifted partial remainder takes the next dividend bit from the top of dvd_r.
  assign part = {rem_r[RW-2:0], dvd_r[N]};

  fp_ratio_divstep #(.W(RW)) u_divstep (
    .part     (part),
    .divisor  ({1'b0, den_r}),
    .rem_next (rem_nxt),
    .q        (qbit)
  );

  // Operand capture and iterative division datapath.
  // Dividend is |num|*2^(WF+1): its bits above position N form the initial
  // remainder, the low N+1 bits are shifted in one per iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r     <= RND_TRUNC;
      neg_r      <= 1'b0;
      num_neg_r  <= 1'b0;
      num_zero_r <= 1'b0;
      den_zero_r <= 1'b0;
      pre_ovf_r  <= 1'b0;
      den_r      <= {(N+1){1'b0}};
      rem_r      <= {RW{1'b0}};
      dvd_r      <= {(N+1){1'b0}};
      quo_r      <= {(N+1){1'b0}};
      cnt_r      <= {CW{1'b0}};
    end else if (accept) begin
      mode_r     <= rnd_type;
      neg_r      <= num_neg ^ den_neg;
      num_neg_r  <= num_neg;
      num_zero_r <= (num == {N{1'b0}});
      den_zero_r <= (den == {N{1'b0}});
      pre_ovf_r  <= pre_ovf;
      den_r      <= den_abs;
      rem_r      <= RW'(num_abs >> WI);
      dvd_r      <= num_abs << (WF + 1);
      quo_r      <= {(N+1){1'b0}};
      cnt_r      <= {CW{1'b0}};
    end else if (state_r == ST_DIV) begin
      rem_r <= rem_nxt;
      dvd_r <= {dvd_r[N-1:0], 1'b0};
      quo_r <= {quo_r[N-1:0], qbit};
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Rounding, sign restoration and saturation of the finished quotient.
  always_comb begin
    guard   = quo_r[0];
    sticky  = |rem_r;
    mag     = {1'b0, quo_r[N:1]};
    up      = round_up(mode_r, guard, sticky, quo_r[1]);
    mag_rnd = mag + {{N{1'b0}}, up};
    if (IS_SIGNED) begin
      if (neg_r) post_ovf = (mag_rnd > SGN_LIM);
      else       post_ovf = (mag_rnd >= SGN_LIM);
    end else begin
      post_ovf = mag_rnd[N];
    end
    if (neg_r) begin
      res_val = ~mag_rnd[N-1:0] + {{(N-1){1'b0}}, 1'b1};
    end else begin
      res_val = mag_rnd[N-1:0];
    end
    sat_neg = {1'b1, {(N-1){1'b0}}};
    if (IS_SIGNED) begin
      sat_pos = {1'b0, {(N-1){1'b1}}};
    end else begin
      sat_pos = {N{1'b1}};
    end
    if (den_zero_r) begin
      dz_nxt  = 1'b1;
      ovf_nxt = 1'b0;
      if (num_zero_r)     out_nxt = {N{1'b0}};
      else if (num_neg_r) out_nxt = sat_neg;
      else                out_nxt = sat_pos;
    end else if (pre_ovf_r || post_ovf) begin
      dz_nxt  = 1'b0;
      ovf_nxt = 1'b1;
      if (neg_r) out_nxt = sat_neg;
      else       out_nxt = sat_pos;
    end else begin
      dz_nxt  = 1'b0;
      ovf_nxt = 1'b0;
      out_nxt = res_val;
    end
  end

  // Result registers: loaded once in RND, held through DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r    <= {N{1'b0}};
      dz_out_r <= 1'b0;
      ovf_r    <= 1'b0;
    end else if (state_r == ST_RND) begin
      out_r    <= out_nxt;
      dz_out_r <= dz_nxt;
      ovf_r    <= ovf_nxt;
    end else begin
      out_r    <= out_r;
      dz_out_r <= dz_out_r;
      ovf_r    <= ovf_r;
    end
  end

  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = (state_r == ST_DONE);
  assign out       = out_r;
  assign dz        = dz_out_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_fp_ratio.sv
// Testbench for fp_ratio: two instances, Q(2.14) (a_*) and Q(4.4) (b_*).
// Expected results are queued when operands are driven and compared when
// each instance hands out a result.
module tb_fp_ratio;

  typedef struct packed {
    logic [15:0] out;
    logic        dz;
    logic        ovf;
  } exp_t;

  logic        clk, rst;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_dz, a_ovf;
  logic [15:0] a_num, a_den, a_out;
  logic [1:0]  a_type;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_dz, b_ovf;
  logic [7:0]  b_num, b_den, b_out;
  logic [1:0]  b_type;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t  q_a[$], q_b[$];
  string t_a[$], t_b[$];

  fp_ratio #(.WI(2), .WF(14), .SIGNED(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .num(a_num), .den(a_den), .rnd_type(a_type), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out(a_out), .dz(a_dz), .ovf(a_ovf)
  );

  fp_ratio #(.WI(4), .WF(4), .SIGNED(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .num(b_num), .den(b_den), .rnd_type(b_type), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out(b_out), .dz(b_dz), .ovf(b_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] o, input logic d, input logic v);
    exp_t e;
    e.out = o;
    e.dz  = d;
    e.ovf = v;
    return e;
  endfunction

  // Reference: magnitude floor(|num|*2^(WF+1)/|den|), guard = LSB, then round/saturate.
  function automatic exp_t model(input int wi, input int wf, input longint nv,
                                 input longint dv, input int mode);
    exp_t   e;
    int     n;
    longint lim, mask, a, b, q, r, m;
    bit     neg, up;
    n    = wi + wf;
    lim  = longint'(1) << (n - 1);
    mask = (longint'(1) << n) - 1;
    e.dz = 1'b0;
    e.ovf = 1'b0;
    if (dv == 0) begin
      e.dz = 1'b1;
      if (nv == 0)     e.out = 16'd0;
      else if (nv < 0) e.out = 16'(lim);
      else             e.out = 16'(lim - 1);
      return e;
    end
    a   = (nv < 0) ? -nv : nv;
    b   = (dv < 0) ? -dv : dv;
    neg = (nv < 0) != (dv < 0);
    q   = (a << (wf + 1)) / b;
    r   = (a << (wf + 1)) % b;
    m   = q >> 1;
    case (mode)
      1:       up = q[0];
      2:       up = q[0] && ((r != 0) || m[0]);
      default: up = 1'b0;
    endcase
    m = m + longint'(up);
    if (neg ? (m > lim) : (m >= lim)) begin
      e.ovf = 1'b1;
      e.out = neg ? 16'(lim) : 16'(lim - 1);
    end else begin
      e.out = neg ? 16'((-m) & mask) : 16'(m & mask);
    end
    return e;
  endfunction

  // Drive one operand pair; when do_wait is set, queue the expectation and
  // measure the acceptance-to-out_valid latency in cycles.
  task automatic send(input int sel, input longint nv, input longint dv, input logic [1:0] m,
                      input exp_t e, input string tag, input bit do_wait);
    int cyc;
    bit hit;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      hit = (sel == 0) ? a_in_ready : b_in_ready;
    end while (!hit && cyc < 200);
    if (!hit) begin
      check_eq({tag, ".rdy_timeout"}, 32'd0, 32'd1);
      return;
    end
    if (sel == 0) begin
      a_num = 16'(nv); a_den = 16'(dv); a_type = m; a_in_valid = 1'b1;
      if (do_wait) begin q_a.push_back(e); t_a.push_back(tag); end
    end else begin
      b_num = 8'(nv); b_den = 8'(dv); b_type = m; b_in_valid = 1'b1;
      if (do_wait) begin q_b.push_back(e); t_b.push_back(tag); end
    end
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    if (do_wait) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
        hit = (sel == 0) ? a_out_valid : b_out_valid;
      end while (!hit && cyc < 100);
      check_eq({tag, ".lat"}, 32'(cyc), (sel == 0) ? 32'd19 : 32'd11);
    end
  endtask

  // Scoreboard for instance a.
  always @(negedge clk) begin : mon_a
    exp_t  e;
    string t;
    if (!rst && a_out_valid && a_out_ready) begin
      if (q_a.size() == 0) begin
        check_eq("a.spurious_out", 32'(a_out_valid), 32'd0);
      end else begin
        e = q_a.pop_front();
        t = t_a.pop_front();
        check_eq({t, ".out"}, 32'(a_out), 32'(e.out));
        check_eq({t, ".dz"},  32'(a_dz),  32'(e.dz));
        check_eq({t, ".ovf"}, 32'(a_ovf), 32'(e.ovf));
      end
    end
  end

  // Scoreboard for instance b.
  always @(negedge clk) begin : mon_b
    exp_t  e;
    string t;
    if (!rst && b_out_valid && b_out_ready) begin
      if (q_b.size() == 0) begin
        check_eq("b.spurious_out", 32'(b_out_valid), 32'd0);
      end else begin
        e = q_b.pop_front();
        t = t_b.pop_front();
        check_eq({t, ".out"}, 32'(b_out), 32'(e.out));
        check_eq({t, ".dz"},  32'(b_dz),  32'(e.dz));
        check_eq({t, ".ovf"}, 32'(b_ovf), 32'(e.ovf));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cnt;
    rst = 1'b1;
    a_in_valid = 1'b0; a_num = 16'd0; a_den = 16'd0; a_type = 2'b00; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_num = 8'd0;  b_den = 8'd0;  b_type = 2'b00; b_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst.a_in_ready", 32'(a_in_ready), 32'd1);
    check_eq("rst.a_out_valid", 32'(a_out_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst.a_out", 32'(a_out), 32'd0);
    check_eq("rst.a_dz", 32'(a_dz), 32'd0);
    check_eq("rst.a_ovf", 32'(a_ovf), 32'd0);
    check_eq("rst.b_in_ready", 32'(b_in_ready), 32'd1);

    // Q(2.14) directed cases
    send(0, 1, 3, 2'b00, mk(16'h1555, 1'b0, 1'b0), "a.1/3.trunc", 1'b1);
    send(0, 1, 3, 2'b01, mk(16'h1555, 1'b0, 1'b0), "a.1/3.half", 1'b1);
    send(0, 1, 3, 2'b10, mk(16'h1555, 1'b0, 1'b0), "a.1/3.even", 1'b1);
    send(0, 1, 3, 2'b11, mk(16'h1555, 1'b0, 1'b0), "a.1/3.m11", 1'b1);
    send(0, 5, 2, 2'b00, mk(16'h7FFF, 1'b0, 1'b1), "a.5/2", 1'b1);
    send(0, -4, 2, 2'b00, mk(16'h8000, 1'b0, 1'b0), "a.-4/2", 1'b1);
    send(0, 2, 1, 2'b00, mk(16'h7FFF, 1'b0, 1'b1), "a.2/1", 1'b1);
    send(0, 7, 0, 2'b00, mk(16'h7FFF, 1'b1, 1'b0), "a.7/0", 1'b1);
    send(0, -7, 0, 2'b01, mk(16'h8000, 1'b1, 1'b0), "a.-7/0", 1'b1);
    send(0, 0, 0, 2'b10, mk(16'h0000, 1'b1, 1'b0), "a.0/0", 1'b1);
    send(0, -32768, 1, 2'b00, mk(16'h8000, 1'b0, 1'b1), "a.min/1", 1'b1);
    send(0, -32768, -32768, 2'b00, mk(16'h4000, 1'b0, 1'b0), "a.min/min", 1'b1);
    send(0, 3, 2, 2'b00, mk(16'h6000, 1'b0, 1'b0), "a.3/2", 1'b1);

    // Q(4.4) directed rounding cases
    send(1, 3, 32, 2'b00, mk(16'h0001, 1'b0, 1'b0), "b.3/32.trunc", 1'b1);
    send(1, 3, 32, 2'b01, mk(16'h0002, 1'b0, 1'b0), "b.3/32.half", 1'b1);
    send(1, 3, 32, 2'b10, mk(16'h0002, 1'b0, 1'b0), "b.3/32.even", 1'b1);
    send(1, 1, 32, 2'b00, mk(16'h0000, 1'b0, 1'b0), "b.1/32.trunc", 1'b1);
    send(1, 1, 32, 2'b01, mk(16'h0001, 1'b0, 1'b0), "b.1/32.half", 1'b1);
    send(1, 1, 32, 2'b10, mk(16'h0000, 1'b0, 1'b0), "b.1/32.even", 1'b1);
    send(1, -3, 32, 2'b00, mk(16'h00FF, 1'b0, 1'b0), "b.-3/32.trunc", 1'b1);
    send(1, -3, 32, 2'b01, mk(16'h00FE, 1'b0, 1'b0), "b.-3/32.half", 1'b1);
    send(1, -3, 32, 2'b10, mk(16'h00FE, 1'b0, 1'b0), "b.-3/32.even", 1'b1);

    // Random operands against the reference model
    for (int i = 0; i < 20; i++) begin
      longint nv, dv;
      int     m;
      nv = longint'($signed(16'($urandom)));
      if ($urandom_range(0, 1) == 1) dv = longint'($signed(8'($urandom)));
      else                           dv = longint'($signed(16'($urandom)));
      m = $urandom_range(0, 3);
      send(0, nv, dv, 2'(m), model(2, 14, nv, dv, m), $sformatf("a.rand%0d", i), 1'b1);
    end
    for (int i = 0; i < 20; i++) begin
      longint nv, dv;
      int     m;
      nv = longint'($signed(8'($urandom)));
      if ($urandom_range(0, 1) == 1) dv = longint'($signed(4'($urandom)));
      else                           dv = longint'($signed(8'($urandom)));
      m = $urandom_range(0, 3);
      send(1, nv, dv, 2'(m), model(4, 4, nv, dv, m), $sformatf("b.rand%0d", i), 1'b1);
    end

    // Back-pressure: result held, operands offered during DONE ignored
    a_out_ready = 1'b0;
    send(0, 1, 3, 2'b01, mk(16'h1555, 1'b0, 1'b0), "a.stall", 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin a_num = 16'd5; a_den = 16'd2; a_in_valid = 1'b1; end
      @(negedge clk);
      check_eq($sformatf("a.stall%0d.out", i), 32'(a_out), 32'h1555);
      check_eq($sformatf("a.stall%0d.valid", i), 32'(a_out_valid), 32'd1);
      check_eq($sformatf("a.stall%0d.in_ready", i), 32'(a_in_ready), 32'd0);
    end
    a_in_valid = 1'b0;
    @(posedge clk);
    #1;
    a_out_ready = 1'b1;
    @(negedge clk);

    // Reset in the middle of a division
    send(0, 7, 3, 2'b00, mk(16'h0000, 1'b0, 1'b0), "a.rst_mid", 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("a.rst_mid.in_ready", 32'(a_in_ready), 32'd1);
    check_eq("a.rst_mid.out", 32'(a_out), 32'd0);
    check_eq("a.rst_mid.dz", 32'(a_dz), 32'd0);
    check_eq("a.rst_mid.ovf", 32'(a_ovf), 32'd0);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (a_out_valid) cnt++;
    end
    check_eq("a.rst_mid.no_valid", 32'(cnt), 32'd0);

    // Let the scoreboards drain
    cnt = 0;
    while ((q_a.size() + q_b.size()) != 0 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("sb.drain", 32'(q_a.size() + q_b.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
